score_event_arbiter: RTL and testbench
======================================

// Module: score_event_arbiter
// PURPOSE
//  Collects good/bad collision events from NREQ independent sources: snake heads, hazards, debug pushbuttons.
//  Arbitrates them round-robin into one serialized stream of single-cycle goodColl/badColl pulses.
//  These pulses feed the score_tracker. Enforces a minimum spacing between pulses, so no event is merged or lost inside the tracker.
//  Blocks scoring once the game is complete.
// PARAMETERS
//  NREQ  4  number of event sources (2..8)
//  GAP   2  idle cycles spent in GAP state after each issued pulse (0..15)
// PORTS
//  clk           in   1            system clock (hz100); single clock domain
//  nRst          in   1            reset: synchronous and active-low
//  goodReq       in   NREQ         per-source good-collision level; each rising edge = 1 event
//  badReq        in   NREQ         per-source bad-collision level; each rising edge = 1 event
//  gameComplete  in   1            from score_tracker; high = stop issuing, flush pending
//  goodColl      out  1            1-cycle pulse to score_tracker goodColl
//  badColl       out  1            1-cycle pulse to score_tracker badColl
//  grantId       out  $clog2(NREQ) source index of the current/last issued pulse
//  busy          out  1            1 when FSM is not IDLE
//  dropped       out  1            1-cycle pulse: an event hit an already-pending flag
// BEHAVIOUR
//  Reset (nRst low at posedge): state=IDLE; all outputs 0; req_q=0; pending flags=0; rrPtr=NREQ-1, so source 0 wins first.
//  Edge detect: rise = req & ~req_q, per bit; req_q <= req every cycle, including while gameComplete is high.
//  Pending flags: pendG[i] and pendB[i], one per source.
//  - A rise sets the flag at that posedge.
//  - A rise on an already-set flag that is not being cleared this cycle pulses dropped next cycle; the flag stays 1.
//  - A rise on a flag cleared by ISSUE in the same cycle leaves the flag set, with no drop.
//  FSM states: IDLE, ISSUE, GAP.
//   IDLE -> ISSUE when any pending flag is set and gameComplete=0.
//   - Winner: first source with any flag, scanning from rrPtr+1 upward mod NREQ.
//   - Within the winner, bad beats good.
//   - At that posedge: goodColl or badColl <= 1; grantId <= winner; rrPtr <= winner; winner's chosen flag <= 0.
//   ISSUE -> GAP when GAP>0, loading gapCnt=GAP-1; ISSUE -> IDLE when GAP=0.
//   - The pulse drops to 0 on leaving ISSUE, so it is exactly 1 cycle wide.
//   GAP: gapCnt decrements each cycle; -> IDLE when gapCnt==0.
//  Latency: a rise sampled at posedge k gives pending=1 after k; the pulse is high for the cycle after posedge k+1.
//   Minimum latency is 2 cycles from an idle FSM.
//  Spacing: back-to-back pulses are separated by GAP+1 low cycles.
//   Throughput is 1 event per GAP+2 cycles.
//  Simultaneous good and bad rise on one source: both flags set; bad is issued first, good on a later turn of that source.
//  Simultaneous rises on many sources: all latch; they are issued in round-robin order.
//  gameComplete=1:
//  - Rises are ignored: no flag set, no dropped.
//  - All pending flags are cleared at the next posedge.
//  - A pulse already in ISSUE completes, and GAP runs out normally.
//  - The FSM then idles until gameComplete falls.
//  Reset mid-operation: an in-flight pulse is cut at the reset posedge; all pending events are discarded.
//  grantId holds its last value until the next ISSUE.
//  goodColl and badColl are never both 1.
//  Width rules: gapCnt is 4 bits; the round-robin scan wraps mod NREQ, including NREQ that is not a power of 2.
// TESTING
//  1. Reset; goodReq[2] rises, cycle 0 -> goodColl=1 in cycle 2 only, grantId=2, busy=1 for cycles 2..4 (GAP=2).
//  2. badReq[0], goodReq[1], goodReq[3] rise together -> pulses bad/0, good/1, good/3, each separated by 3 low cycles.
//  3. goodReq[1] and badReq[1] rise together -> badColl first, then goodColl, both grantId=1; dropped stays 0.
//  4. goodReq[0] toggles 0->1->0->1 while grant is held by long pending queue -> exactly one dropped pulse; one goodColl for source 0.
//  5. 3 events pending, gameComplete rises -> in-flight pulse finishes, pending flushed, no further pulses; new rises ignored until gameComplete=0.
//  6. Hold nRst low during an ISSUE cycle -> all outputs 0 next cycle, and the previously pending events are never issued.

Source files
------------

// File: rtl/score_event_arbiter.sv
// score_event_arbiter: latches rising-edge good/bad events from NREQ sources,
// picks one source round-robin (bad before good within a source), and emits
// single-cycle goodColl/badColl pulses spaced by a GAP-cycle cooldown.
module score_event_arbiter #(
  parameter int NREQ = 4,
  parameter int GAP  = 2
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic [NREQ-1:0]         goodReq,
  input  logic [NREQ-1:0]         badReq,
  input  logic                    gameComplete,
  output logic                    goodColl,
  output logic                    badColl,
  output logic [$clog2(NREQ)-1:0] grantId,
  output logic                    busy,
  output logic                    dropped
);

  localparam int IW = $clog2(NREQ);
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t          state, state_next;
  logic [NREQ-1:0] good_q, bad_q;
  logic [NREQ-1:0] pend_g, pend_b;
  logic [NREQ-1:0] rise_g, rise_b;
  logic [NREQ-1:0] clr_g, clr_b;
  logic [IW-1:0]   rr_ptr, winner;
  logic [3:0]      gap_cnt;
  logic            found, take, choose_bad;
  int unsigned     idx;

  assign rise_g = goodReq & ~good_q;
  assign rise_b = badReq & ~bad_q;
  assign busy   = (state != S_IDLE);

  // Round-robin scan starting just after the last granted source.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && (pend_g[idx] || pend_b[idx])) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  // Next-state logic; take marks the IDLE->ISSUE transition.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!gameComplete && |(pend_g | pend_b)) begin
          take       = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = (GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_cnt == 4'd0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Which pending flag the current grant consumes.
  always_comb begin
    choose_bad = pend_b[winner];
    clr_g      = '0;
    clr_b      = '0;
    if (take) begin
      if (choose_bad) clr_b = NREQ'(1) << winner;
      else            clr_g = NREQ'(1) << winner;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!nRst) state <= S_IDLE;
    else       state <= state_next;
  end

  // Edge history, pending flags, pulse outputs, pointer and gap counter.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      good_q   <= '0;
      bad_q    <= '0;
      pend_g   <= '0;
      pend_b   <= '0;
      goodColl <= 1'b0;
      badColl  <= 1'b0;
      grantId  <= '0;
      dropped  <= 1'b0;
      rr_ptr   <= IW'(NREQ - 1);
      gap_cnt  <= '0;
    end else begin
      good_q   <= goodReq;
      bad_q    <= badReq;
      goodColl <= take && !choose_bad;
      badColl  <= take && choose_bad;
      if (take) begin
        grantId <= winner;
        rr_ptr  <= winner;
      end
      if (state == S_ISSUE)
        gap_cnt <= GAP_LOAD;
      else if (state == S_GAP && gap_cnt != 4'd0)
        gap_cnt <= gap_cnt - 4'd1;
      // A rise landing on a flag being consumed this cycle re-arms it rather than dropping.
      if (gameComplete) begin
        pend_g  <= '0;
        pend_b  <= '0;
        dropped <= 1'b0;
      end else begin
        pend_g  <= (pend_g & ~clr_g) | rise_g;
        pend_b  <= (pend_b & ~clr_b) | rise_b;
        dropped <= |(rise_g & pend_g & ~clr_g) | |(rise_b & pend_b & ~clr_b);
      end
    end
  end

endmodule

// File: tb/tb_score_event_arbiter.sv
// Testbench for score_event_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against an event/timestamp reference model.
module tb_score_event_arbiter;

  localparam int NREQ = 4;
  localparam int GAP  = 2;

  logic            clk = 1'b0;
  logic            nRst = 1'b0;
  logic [NREQ-1:0] goodReq = '0;
  logic [NREQ-1:0] badReq = '0;
  logic            gameComplete = 1'b0;
  logic            goodColl, badColl, busy, dropped;
  logic [1:0]      grantId;

  score_event_arbiter #(.NREQ(NREQ), .GAP(GAP)) dut (
    .clk(clk), .nRst(nRst), .goodReq(goodReq), .badReq(badReq),
    .gameComplete(gameComplete), .goodColl(goodColl), .badColl(badColl),
    .grantId(grantId), .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;

  // Reference model: pending sets plus the timestamp of the last issued pulse.
  logic [NREQ-1:0] m_gq = '0, m_bq = '0, m_pg = '0, m_pb = '0;
  int     m_rr = NREQ - 1;
  longint m_cyc = 0;
  longint m_last = -1000;
  logic   e_good = 0, e_bad = 0, e_busy = 0, e_drop = 0;
  logic [1:0] e_gid = '0;

  // Pulses observed on the DUT outputs: 16*bad + source, with issue cycle.
  int     pulses[$];
  longint pulse_cyc[$];
  int     drops = 0;

  task automatic model_edge();
    logic [NREQ-1:0] rg, rb, cg, cb;
    int w;
    m_cyc++;
    if (!nRst) begin
      m_gq = '0; m_bq = '0; m_pg = '0; m_pb = '0;
      m_rr = NREQ - 1; m_last = -1000;
      e_good = 0; e_bad = 0; e_drop = 0; e_busy = 0; e_gid = '0;
      return;
    end
    rg = goodReq & ~m_gq;
    rb = badReq & ~m_bq;
    cg = '0; cb = '0;
    e_good = 0; e_bad = 0; e_drop = 0;
    if (!gameComplete && (m_cyc - m_last >= GAP + 2) && (|(m_pg | m_pb))) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int s = (m_rr + k) % NREQ;
        if (w < 0 && (m_pg[s] || m_pb[s])) w = s;
      end
      if (m_pb[w]) begin e_bad = 1; cb[w] = 1'b1; end
      else         begin e_good = 1; cg[w] = 1'b1; end
      e_gid = 2'(w);
      m_rr = w;
      m_last = m_cyc;
    end
    if (gameComplete) begin
      m_pg = '0; m_pb = '0;
    end else begin
      e_drop = (|(rg & m_pg & ~cg)) || (|(rb & m_pb & ~cb));
      m_pg = (m_pg & ~cg) | rg;
      m_pb = (m_pb & ~cb) | rb;
    end
    m_gq = goodReq;
    m_bq = badReq;
    e_busy = (m_cyc - m_last) <= GAP;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (goodColl === 1'b1 || badColl === 1'b1) begin
      pulses.push_back((badColl === 1'b1 ? 16 : 0) + int'(grantId));
      pulse_cyc.push_back(m_cyc);
    end
    if (dropped === 1'b1) drops++;
  endtask

  function automatic logic [5:0] obs_vec();
    return {goodColl, badColl, grantId, busy, dropped};
  endfunction

  function automatic logic [5:0] exp_vec();
    return {e_good, e_bad, e_gid, e_busy, e_drop};
  endfunction

  task automatic do_reset();
    nRst = 1'b0; goodReq = '0; badReq = '0; gameComplete = 1'b0;
    step(); step();
    nRst = 1'b1;
    pulses.delete(); pulse_cyc.delete(); drops = 0;
  endtask

  task automatic test_reset();
    nRst = 1'b0; goodReq = 4'b1111; badReq = 4'b1111;
    step(); step();
    n_checks++;
    if (obs_vec() !== 6'b0)
      $display("FAIL reset_outputs: got %b expected %b", obs_vec(), 6'b0);
    else n_pass++;
    n_checks++;
    if (obs_vec() !== exp_vec())
      $display("FAIL reset_model: got %b expected %b", obs_vec(), exp_vec());
    else n_pass++;
    do_reset();
  endtask

  task automatic test_single();
    logic exp_g[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic exp_b[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    goodReq = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (goodColl !== exp_g[i] || busy !== exp_b[i] || badColl !== 1'b0 ||
          (i >= 1 && grantId !== 2'd2))
        $display("FAIL single step%0d: got good=%b busy=%b bad=%b id=%0d expected good=%b busy=%b bad=0 id=2",
                 i, goodColl, busy, badColl, grantId, exp_g[i], exp_b[i]);
      else n_pass++;
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL single_model step%0d: got %b expected %b", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    goodReq = '0;
  endtask

  task automatic test_multi();
    do_reset();
    badReq = 4'b0001; goodReq = 4'b1010;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL multi_model step%0d: got %b expected %b", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (pulses.size() != 3 || pulses[0] != 16 || pulses[1] != 1 || pulses[2] != 3 ||
        pulse_cyc[1] - pulse_cyc[0] != GAP + 2 || pulse_cyc[2] - pulse_cyc[1] != GAP + 2)
      $display("FAIL multi_order: got %p expected '{16,1,3} spaced %0d", pulses, GAP + 2);
    else n_pass++;
    badReq = '0; goodReq = '0;
  endtask

  task automatic test_same_source();
    do_reset();
    goodReq = 4'b0010; badReq = 4'b0010;
    for (int i = 0; i < 15; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL same_src_model step%0d: got %b expected %b", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (pulses.size() != 2 || pulses[0] != 17 || pulses[1] != 1 || drops != 0)
      $display("FAIL same_src: got %p drops=%0d expected '{17,1} drops=0", pulses, drops);
    else n_pass++;
    goodReq = '0; badReq = '0;
  endtask

  task automatic test_drop();
    do_reset();
    badReq = 4'b1110;
    step();
    goodReq[0] = 1'b1; step();
    goodReq[0] = 1'b0; step();
    goodReq[0] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL drop_model step%0d: got %b expected %b", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (drops != 1 || pulses.size() != 4 || pulses[0] != 17 || pulses[1] != 18 ||
        pulses[2] != 19 || pulses[3] != 0)
      $display("FAIL drop: got drops=%0d %p expected drops=1 '{17,18,19,0}", drops, pulses);
    else n_pass++;
    goodReq = '0; badReq = '0;
  endtask

  task automatic test_game_complete();
    do_reset();
    goodReq = 4'b0111;
    step(); step();
    gameComplete = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) goodReq[3] = 1'b1;
      if (i == 5) goodReq[0] = 1'b0;
      if (i == 7) goodReq[0] = 1'b1;
      step();
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL gc_model step%0d: got %b expected %b", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (pulses.size() != 1 || pulses[0] != 0 || drops != 0 || busy !== 1'b0)
      $display("FAIL gc_flush: got %p drops=%0d busy=%b expected '{0} drops=0 busy=0", pulses, drops, busy);
    else n_pass++;
    gameComplete = 1'b0;
    for (int i = 0; i < 8; i++) step();
    n_checks++;
    if (pulses.size() != 1)
      $display("FAIL gc_after_release: got %0d pulses expected 1", pulses.size());
    else n_pass++;
    goodReq[3] = 1'b0; step();
    goodReq[3] = 1'b1;
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (pulses.size() != 2 || pulses[1] != 3)
      $display("FAIL gc_resume: got %p expected '{0,3}", pulses);
    else n_pass++;
    goodReq = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    badReq = 4'b1011;
    step(); step();
    n_checks++;
    if (badColl !== 1'b1 || grantId !== 2'd0)
      $display("FAIL mid_issue: got bad=%b id=%0d expected bad=1 id=0", badColl, grantId);
    else n_pass++;
    nRst = 1'b0; badReq = '0;
    step();
    n_checks++;
    if (obs_vec() !== 6'b0)
      $display("FAIL mid_reset: got %b expected %b", obs_vec(), 6'b0);
    else n_pass++;
    nRst = 1'b1;
    for (int i = 0; i < 15; i++) step();
    n_checks++;
    if (pulses.size() != 1 || busy !== 1'b0)
      $display("FAIL mid_discard: got %0d pulses busy=%b expected 1 pulse busy=0", pulses.size(), busy);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3, 0) == 0) goodReq = goodReq ^ NREQ'($urandom);
      if ($urandom_range(3, 0) == 0) badReq = badReq ^ NREQ'($urandom);
      if ($urandom_range(63, 0) == 0) gameComplete = ~gameComplete;
      nRst = ($urandom_range(499, 0) != 0);
      step();
      n_checks++;
      if (obs_vec() !== exp_vec() || (goodColl && badColl))
        $display("FAIL random cyc%0d: got %b expected %b", m_cyc, obs_vec(), exp_vec());
      else n_pass++;
    end
    nRst = 1'b1; gameComplete = 1'b0; goodReq = '0; badReq = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_same_source();
    test_drop();
    test_game_complete();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
